// File: rtl/sram_ctrl.sv
// sram_ctrl: single-byte read/write sequencer for a 32Kx8 asynchronous SRAM.
// Every pin-facing signal comes straight from a flop. The output flops are
// loaded from the next-state decode, so strobes change on the same edge as
// the state. One 4-bit down-counter times every state that has a duration.
`timescale 1ns/1ps
module sram_ctrl #(
   parameter int unsigned RD_WAIT  = 4,
   parameter int unsigned WR_SETUP = 1,
   parameter int unsigned WR_PULSE = 2,
   parameter int unsigned WR_HOLD  = 1,
   parameter int unsigned TURN     = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ,
   input  logic        WE,
   input  logic [14:0] ADDR,
   input  logic [7:0]  WDATA,
   output logic        BUSY,
   output logic        DONE,
   output logic [7:0]  RDATA,
   output logic [14:0] SRAM_ADDR,
   inout  wire  [7:0]  SRAM_DATA,
   output logic        nCE,
   output logic        nOE,
   output logic        nWE
);

   localparam int unsigned AW = 15;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 4;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RD_ACC = 3'd1;
   localparam logic [2:0] S_WR_SET = 3'd2;
   localparam logic [2:0] S_WR_PUL = 3'd3;
   localparam logic [2:0] S_WR_HLD = 3'd4;
   localparam logic [2:0] S_RECOV  = 3'd5;

   // The counter is loaded with (duration - 1) and the state exits when it reaches 0.
   localparam logic [CW-1:0] RD_LOAD  = CW'(RD_WAIT - 32'd1);
   localparam logic [CW-1:0] SET_LOAD = CW'(WR_SETUP - 32'd1);
   localparam logic [CW-1:0] PUL_LOAD = CW'(WR_PULSE - 32'd1);
   localparam logic [CW-1:0] HLD_LOAD = CW'(WR_HOLD - 32'd1);
   // TURN=0 still costs one recovery cycle.
   localparam logic [CW-1:0] REC_LOAD = (TURN > 32'd1) ? CW'(TURN - 32'd1) : CW'(0);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [AW-1:0] addr_q,  addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          nce_q,   nce_d;
   logic          noe_q,   noe_d;
   logic          nwe_q,   nwe_d;
   logic          drv_q,   drv_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;

   // State, counter, captured request and registered pin outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         nce_q   <= 1'b1;
         noe_q   <= 1'b1;
         nwe_q   <= 1'b1;
         drv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         nce_q   <= nce_d;
         noe_q   <= noe_d;
         nwe_q   <= nwe_d;
         drv_q   <= drv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state sequencing and the pin values for the state being entered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      nce_d   = 1'b1;
      noe_d   = 1'b1;
      nwe_d   = 1'b1;
      drv_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (REQ) begin
               addr_d  = ADDR;
               wdata_d = WDATA;
               if (WE) begin
                  state_d = S_WR_SET;
                  cnt_d   = SET_LOAD;
               end else begin
                  state_d = S_RD_ACC;
                  cnt_d   = RD_LOAD;
               end
            end
         end
         S_RD_ACC: begin
            if (cnt_q == '0) begin
               // Last edge of the access window: capture the byte on the bus.
               rdata_d = SRAM_DATA;
               state_d = S_RECOV;
               cnt_d   = REC_LOAD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_WR_SET: begin
            if (cnt_q == '0) begin
               state_d = S_WR_PUL;
               cnt_d   = PUL_LOAD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_WR_PUL: begin
            if (cnt_q == '0) begin
               state_d = S_WR_HLD;
               cnt_d   = HLD_LOAD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_WR_HLD: begin
            if (cnt_q == '0) begin
               state_d = S_RECOV;
               cnt_d   = REC_LOAD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RECOV: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Pin values follow the state being entered, so they line up with it.
      case (state_d)
         S_RD_ACC: begin
            nce_d = 1'b0;
            noe_d = 1'b0;
         end
         S_WR_SET, S_WR_HLD: begin
            nce_d = 1'b0;
            drv_d = 1'b1;
         end
         S_WR_PUL: begin
            nce_d = 1'b0;
            nwe_d = 1'b0;
            drv_d = 1'b1;
         end
         default: begin
            nce_d = 1'b1;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_RECOV) && (state_q != S_RECOV);
   end

   // The controller drives the data bus only during write states.
   assign SRAM_DATA = drv_q ? wdata_q : {DW{1'bz}};

   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign RDATA     = rdata_q;
   assign SRAM_ADDR = addr_q;
   assign nCE       = nce_q;
   assign nOE       = noe_q;
   assign nWE       = nwe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a 24 MHz clock, a timed behavioural model of a 120 ns SRAM,
// table vectors, randomized accesses against a reference memory, and
// hand-written abort and under-timing sequences.
`timescale 1ns/1ps
module tb_sram_ctrl;

   localparam int unsigned RD_WAIT  = 4;
   localparam int unsigned WR_SETUP = 1;
   localparam int unsigned WR_PULSE = 2;
   localparam int unsigned WR_HOLD  = 1;
   localparam int unsigned TURN     = 1;
   localparam realtime     T_HALF   = 20.835;
   localparam realtime     T_ACC    = 125.0;  // 120 ns part plus 5 ns board delay
   localparam realtime     T_WLATCH = 30.0;
   localparam int          MAXC     = 48;

   logic        CLK = 1'b0;
   logic        RESET, REQ, WE;
   logic [14:0] ADDR;
   logic [7:0]  WDATA;
   logic        BUSY, DONE;
   logic [7:0]  RDATA;
   logic [14:0] SRAM_ADDR;
   wire  [7:0]  SRAM_DATA;
   logic        nCE, nOE, nWE;

   // Second controller, deliberately under-timed against the same part.
   logic        s_req;
   logic [14:0] s_addr;
   logic        s_busy, s_done, s_nce, s_noe, s_nwe;
   logic [7:0]  s_rdata;
   logic [14:0] s_sram_addr;
   wire  [7:0]  s_data;

   int checks = 0;
   int errors = 0;

   sram_ctrl #(.RD_WAIT(RD_WAIT), .WR_SETUP(WR_SETUP), .WR_PULSE(WR_PULSE),
               .WR_HOLD(WR_HOLD), .TURN(TURN)) u_dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
      .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .SRAM_ADDR(SRAM_ADDR),
      .SRAM_DATA(SRAM_DATA), .nCE(nCE), .nOE(nOE), .nWE(nWE));

   sram_ctrl #(.RD_WAIT(2)) u_short (
      .CLK(CLK), .RESET(RESET), .REQ(s_req), .WE(1'b0), .ADDR(s_addr), .WDATA(8'h00),
      .BUSY(s_busy), .DONE(s_done), .RDATA(s_rdata), .SRAM_ADDR(s_sram_addr),
      .SRAM_DATA(s_data), .nCE(s_nce), .nOE(s_noe), .nWE(s_nwe));

   always #(T_HALF) CLK = ~CLK;

   // Released bus reads as 0xFF.
   pullup (SRAM_DATA);
   pullup (s_data);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pre_val(input logic [14:0] a);
      return (a == 15'd0) ? 8'h3C : (a[7:0] ^ 8'(a[14:8]) ^ 8'h96);
   endfunction

   // ---------------- SRAM model: data valid T_ACC after nCE&nOE fall ----------------
   logic [7:0] mem [0:32767];
   logic       rd_act;
   logic       rd_valid = 1'b0;
   realtime    t_rd = 0.0;
   realtime    t_we = 0.0;

   assign rd_act    = !nCE && !nOE && nWE;
   assign SRAM_DATA = (rd_act && rd_valid) ? mem[SRAM_ADDR] : 8'bz;

   always @(posedge rd_act) begin
      t_rd = $realtime;
      fork
         begin
            #(T_ACC);
            if (rd_act && (($realtime - t_rd) >= T_ACC - 0.001)) rd_valid = 1'b1;
         end
      join_none
   end
   always @(negedge rd_act) rd_valid = 1'b0;

   always @(negedge nWE) t_we = $realtime;
   always @(posedge nWE) begin
      if (!nCE && (($realtime - t_we) >= T_WLATCH)) mem[SRAM_ADDR] = SRAM_DATA;
   end

   // Model behind the under-timed controller: every location holds 0x3C.
   logic    s_rd_act;
   logic    s_rd_valid = 1'b0;
   realtime s_t_rd = 0.0;

   assign s_rd_act = !s_nce && !s_noe && s_nwe;
   assign s_data   = (s_rd_act && s_rd_valid) ? 8'h3C : 8'bz;

   always @(posedge s_rd_act) begin
      s_t_rd = $realtime;
      fork
         begin
            #(T_ACC);
            if (s_rd_act && (($realtime - s_t_rd) >= T_ACC - 0.001)) s_rd_valid = 1'b1;
         end
      join_none
   end
   always @(negedge s_rd_act) s_rd_valid = 1'b0;

   // ---------------- pin invariants, sampled mid-cycle ----------------
   logic        win = 1'b0;
   logic        win_wr = 1'b0;
   logic [14:0] win_a = '0;
   logic [7:0]  win_d = '0;

   always @(negedge CLK) begin
      if (!RESET) begin
         chk("nOE/nWE both low", {63'd0, (!nOE && !nWE)}, 64'd0);
         if (!nCE) begin
            if (!win) begin
               win    = 1'b1;
               win_a  = SRAM_ADDR;
               win_d  = SRAM_DATA;
               win_wr = nOE;
            end else begin
               chk("addr stable in nCE window", 64'(SRAM_ADDR), 64'(win_a));
               if (win_wr) chk("wdata stable in nCE window", 64'(SRAM_DATA), 64'(win_d));
            end
         end else begin
            win = 1'b0;
         end
      end
   end

   // ---------------- reference: expected timeline of one access ----------------
   logic [7:0] ref_mem [int];
   logic [7:0] last_rd = 8'h00;

   function automatic logic [7:0] ref_read(input logic [14:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pre_val(a);
   endfunction

   // One access from the REQ edge (cycle 0) until the first IDLE cycle;
   // returns at that IDLE cycle's falling edge, so a follow-on call is back-to-back.
   task automatic access(input logic we_i, input logic [14:0] a, input logic [7:0] d,
                         input bit spurious, input logic [7:0] exp_rd, input string tag);
      logic [63:0] m_ce, m_oe, m_we, e_ce, e_oe, e_we;
      int          n_acc, e_idle, done_n, done_at, idle_at;
      logic [7:0]  rd_at_done;
      n_acc  = we_i ? int'(WR_SETUP + WR_PULSE + WR_HOLD) : int'(RD_WAIT);
      e_idle = n_acc + 1 + ((TURN == 0) ? 1 : int'(TURN));
      e_ce = '0; e_oe = '0; e_we = '0;
      for (int i = 1; i <= n_acc; i++) begin
         e_ce[i] = 1'b1;
         if (!we_i) e_oe[i] = 1'b1;
         if (we_i && i > int'(WR_SETUP) && i <= int'(WR_SETUP + WR_PULSE)) e_we[i] = 1'b1;
      end
      m_ce = '0; m_oe = '0; m_we = '0;
      done_n = 0; done_at = -1; idle_at = -1; rd_at_done = 8'h00;

      REQ = 1'b1; WE = we_i; ADDR = a; WDATA = d;
      @(posedge CLK);
      #1;
      REQ = 1'b0; WE = 1'($urandom); ADDR = 15'($urandom); WDATA = 8'($urandom);
      for (int k = 1; k < MAXC && idle_at < 0; k++) begin
         @(negedge CLK);
         if (!nCE) m_ce[k] = 1'b1;
         if (!nOE) m_oe[k] = 1'b1;
         if (!nWE) m_we[k] = 1'b1;
         if (DONE) begin
            done_n++;
            if (done_at < 0) begin
               done_at    = k;
               rd_at_done = RDATA;
            end
         end
         if (!BUSY) idle_at = k;
         if (!we_i && !nOE && !rd_valid) chk({tag, " bus released on read"}, 64'(SRAM_DATA), 64'hFF);
         if (we_i && !nCE) chk({tag, " write data on bus"}, 64'(SRAM_DATA), 64'(d));
         if (spurious && k == 2) begin
            REQ = 1'b1; WE = ~we_i; ADDR = ~a; WDATA = ~d;
         end
         if (spurious && k == 4) REQ = 1'b0;
      end
      REQ = 1'b0;
      chk({tag, " nCE low cycles"}, m_ce, e_ce);
      chk({tag, " nOE low cycles"}, m_oe, e_oe);
      chk({tag, " nWE low cycles"}, m_we, e_we);
      chk({tag, " DONE pulses"}, 64'(done_n), 64'd1);
      chk({tag, " DONE cycle"}, 64'(done_at), 64'(n_acc + 1));
      chk({tag, " first IDLE cycle"}, 64'(idle_at), 64'(e_idle));
      chk({tag, " RDATA at DONE"}, 64'(rd_at_done), 64'(exp_rd));
      chk({tag, " RDATA held"}, 64'(RDATA), 64'(exp_rd));
   endtask

   typedef struct {
      logic        we;
      logic [14:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp_rdata;
      bit          spurious;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [6];
      logic        we_r;
      logic [14:0] a_r;
      logic [7:0]  d_r, e_r;
      int          s_seen, done_cnt;

      RESET = 1'b1; REQ = 1'b0; WE = 1'b0; ADDR = '0; WDATA = '0;
      s_req = 1'b0; s_addr = '0;
      for (int i = 0; i < 32768; i++) mem[i] = pre_val(15'(i));

      // Reset state.
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset nCE", 64'(nCE), 64'd1);
      chk("reset nOE", 64'(nOE), 64'd1);
      chk("reset nWE", 64'(nWE), 64'd1);
      chk("reset SRAM_ADDR", 64'(SRAM_ADDR), 64'd0);
      chk("reset bus released", 64'(SRAM_DATA), 64'hFF);
      chk("reset BUSY", 64'(BUSY), 64'd0);
      chk("reset DONE", 64'(DONE), 64'd0);
      chk("reset RDATA", 64'(RDATA), 64'd0);
      RESET = 1'b0;
      @(negedge CLK);

      // Directed vectors, issued back-to-back in the first IDLE cycle.
      tbl[0] = '{1'b1, 15'h1234, 8'h5A, 8'h00, 1'b0};
      tbl[1] = '{1'b0, 15'h1234, 8'h00, 8'h5A, 1'b0};
      tbl[2] = '{1'b1, 15'h7FFF, 8'hA5, 8'h5A, 1'b0};
      tbl[3] = '{1'b0, 15'h0000, 8'h00, 8'h3C, 1'b0};
      tbl[4] = '{1'b0, 15'h7FFF, 8'h11, 8'hA5, 1'b0};
      tbl[5] = '{1'b0, 15'h1234, 8'h22, 8'h5A, 1'b1};
      foreach (tbl[i]) begin
         access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].spurious, tbl[i].exp_rdata,
                $sformatf("vec%0d", i));
         if (tbl[i].we) ref_mem[int'(tbl[i].addr)] = tbl[i].wdata;
         else last_rd = tbl[i].exp_rdata;
      end

      // Randomized accesses over a small address pool, including the top of memory.
      for (int n = 0; n < 60; n++) begin
         we_r = 1'($urandom_range(0, 1));
         a_r  = 15'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 15'h7FF0 : 15'h0000);
         d_r  = we_r ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 254));
         if (we_r) begin
            e_r = last_rd;
         end else begin
            e_r     = ref_read(a_r);
            last_rd = e_r;
         end
         access(we_r, a_r, d_r, ($urandom_range(0, 3) == 0), e_r, $sformatf("rnd%0d", n));
         if (we_r) ref_mem[int'(a_r)] = d_r;
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
      end

      // RD_WAIT=2 samples at ~83 ns, before the 120 ns part drives: released bus.
      @(negedge CLK);
      s_addr = 15'h0100;
      s_req  = 1'b1;
      @(posedge CLK);
      #1;
      s_req  = 1'b0;
      s_seen = 0;
      for (int k = 0; k < 20 && s_seen == 0; k++) begin
         @(negedge CLK);
         if (s_done) s_seen = 1;
      end
      chk("short RD_WAIT DONE seen", 64'(s_seen), 64'd1);
      chk("short RD_WAIT reads released bus", 64'(s_rdata), 64'hFF);
      repeat (4) @(negedge CLK);

      // Reset during the write pulse aborts on the next edge.
      REQ = 1'b1; WE = 1'b1; ADDR = 15'h0042; WDATA = 8'hA5;
      @(posedge CLK);
      #1;
      REQ = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      @(negedge CLK);
      chk("abort: nWE low before reset", 64'(nWE), 64'd0);
      RESET = 1'b1;
      @(negedge CLK);
      chk("abort nCE", 64'(nCE), 64'd1);
      chk("abort nOE", 64'(nOE), 64'd1);
      chk("abort nWE", 64'(nWE), 64'd1);
      chk("abort bus released", 64'(SRAM_DATA), 64'hFF);
      chk("abort BUSY", 64'(BUSY), 64'd0);
      chk("abort RDATA", 64'(RDATA), 64'd0);
      RESET    = 1'b0;
      done_cnt = (DONE) ? 1 : 0;
      repeat (10) begin
         @(negedge CLK);
         if (DONE) done_cnt++;
      end
      chk("abort DONE never pulses", 64'(done_cnt), 64'd0);
      ref_mem.delete(int'(15'h0042));

      // Controller recovers cleanly after the abort.
      e_r = ref_read(15'h7FFF);
      access(1'b0, 15'h7FFF, 8'h00, 1'b0, e_r, "post-abort read");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Synchronous initiator for the 32K×8 asynchronous SRAM parts (120 ns access), such as the work RAM banks. It accepts single-byte read/write requests from a host-side request port and sequences ADDR/nCE/nOE/nWE/DATA with cycle-counted setup, pulse, hold and turnaround. Timing margins are set by parameters. It sits between the CPU/bus arbiter logic and the SRAM pins, and owns the tristate of the SRAM data bus.

## Interface
Parameters:
- RD_WAIT, 4, cycles nCE/nOE held low before read data is sampled (1..15)
- WR_SETUP, 1, cycles address/data/nCE valid before nWE falls (1..15)
- WR_PULSE, 2, cycles nWE held low (1..15)
- WR_HOLD, 1, cycles address/data/nCE held after nWE rises (1..15)
- TURN, 1, idle cycles after each access, all strobes high, bus released (0..15)

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- REQ  in  1  request strobe, sampled only in IDLE
- WE  in  1  1 = write, 0 = read; captured with REQ
- ADDR  in  15  byte address; captured with REQ
- WDATA  in  8  write data; captured with REQ
- BUSY  out  1  high from the cycle after acceptance until return to IDLE
- DONE  out  1  one-cycle pulse at access completion
- RDATA  out  8  last read byte; holds until the next read completes
- SRAM_ADDR  out  15  SRAM address
- SRAM_DATA  inout  8  SRAM data bus; driven only during write states, else high-Z
- nCE, nOE, nWE  out  1 each  SRAM strobes, active low, registered

## Operation
- States: IDLE, RD_ACC, WR_SET, WR_PUL, WR_HLD, RECOV. One 4-bit down-counter is shared by all timed states.
- IDLE: nCE=nOE=nWE=1, bus released, BUSY=0. With REQ=1, capture ADDR/WE/WDATA, load the counter, and go to RD_ACC (WE=0) or WR_SET (WE=1).
- RD_ACC: SRAM_ADDR=captured, nCE=0, nOE=0, nWE=1. After RD_WAIT cycles, latch SRAM_DATA into RDATA at the final edge and go to RECOV.
- WR_SET: nCE=0, nOE=1, nWE=1, bus driven with captured data. After WR_SETUP cycles go to WR_PUL.
- WR_PUL: as WR_SET but nWE=0. After WR_PULSE cycles go to WR_HLD.
- WR_HLD: nWE=1, nCE=0, data still driven. After WR_HOLD cycles go to RECOV.
- RECOV: all strobes high, bus released, DONE=1 in the first RECOV cycle only. Stay TURN cycles (TURN=0 means one cycle), then go to IDLE.
- REQ while BUSY is ignored, not queued. The host re-issues it after BUSY falls.
- Invariants, asserted in the bench:
  - nOE and nWE are never low together.
  - SRAM_DATA is never driven while nOE=0.
  - SRAM_ADDR and the driven data are stable for the whole nCE=0 window.

## Timing
- Reset values: nCE=nOE=nWE=1, SRAM_ADDR=0, bus high-Z, BUSY=0, DONE=0, RDATA=0, state IDLE, counter 0.
- RESET mid-access aborts on the next edge. Strobes rise in the same cycle, and DONE is not emitted. SRAM contents after an abort during WR_PUL are undefined.
- Cycle 0 is the REQ edge.
- Read:
  - nCE/nOE are low from cycle 1 to RD_WAIT.
  - RDATA is valid and DONE=1 at cycle RD_WAIT+1.
  - State is IDLE at cycle RD_WAIT+1+max(TURN,1).
- Write:
  - nWE is low from cycle WR_SETUP+1 to WR_SETUP+WR_PULSE.
  - DONE is at cycle WR_SETUP+WR_PULSE+WR_HOLD+1.
- Back-to-back: a REQ presented in the IDLE cycle is accepted, so the minimum period is access length + RECOV length + 1.
- Parameter rule: at 24 MHz (41.67 ns/cycle), RD_WAIT×period must exceed 120 ns plus board delay, so RD_WAIT≥4. WR_PULSE×period must exceed the 30 ns device latch time.
- SRAM_ADDR wraps naturally at 15 bits; no range check is done.

## Test plan
- Write 0x5A to 0x1234 (defaults) -> nWE low exactly in cycles 2–3, nCE low cycles 1–4, DONE at cycle 5, BUSY low at cycle 6, no overlap error.
- Read 0x1234 after that write -> nOE low cycles 1–4, RDATA=0x5A and DONE at cycle 5, bus never driven by the controller.
- Write 0xA5 to 0x7FFF, then immediately read 0x0000 (preloaded 0x3C) in the first IDLE cycle -> RDATA=0x3C, and location 0x7FFF reads back 0xA5.
- REQ pulsed at cycles 2 and 3 during a read -> ignored, exactly one DONE, RDATA unchanged by the extra pulses.
- RESET asserted at cycle 3 of a write -> next edge: all strobes high, bus high-Z, BUSY=0, DONE never pulses, RDATA=0.
- RD_WAIT=2 at 41.67 ns against the 120 ns model -> RDATA mismatches. This confirms the bench detects under-timed parameters; the default of 4 passes.
